// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring radix-2 iterations on operand magnitudes, then sign fix-up.
// Optional macro DIV_APPROX_EN skips the low APPROX_BITS quotient bits and forces the remainder to 0.
module signed_seq_divider #(
  parameter int N           = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

`ifdef DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif
  localparam int SKIP = APPROX_EN ? APPROX_BITS : 0;
  localparam int ITER = N - SKIP;
  localparam int CW   = $clog2(N);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sh;     // dividend magnitude, consumed MSB first
  logic [N-1:0]  b_mag;
  logic [N-1:0]  prem;
  logic [N-1:0]  q_sh;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic [N-1:0]  q_full;

  // Unsigned N-bit magnitude holds 2^(N-1) exactly, so the most negative operand needs no special width.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  // prem < |divisor| keeps the trial difference within (-|b|, |b|), so N+1 signed bits suffice.
  assign shifted  = {prem, a_sh[N-1]};
  assign diff     = shifted - {1'b0, b_mag};
  assign q_full   = q_sh << SKIP;
  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      a_sh        <= '0;
      b_mag       <= '0;
      prem        <= '0;
      q_sh        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh        <= mag(dividend);
            b_mag       <= mag(divisor);
            prem        <= '0;
            q_sh        <= '0;
            neg_q       <= dividend[N-1] ^ divisor[N-1];
            neg_r       <= dividend[N-1];
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (dividend == MIN_VAL && divisor == '1) begin
              quotient  <= MIN_VAL;
              remainder <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= CW'(ITER - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_sh <= a_sh << 1;
          if (!diff[N]) begin
            prem <= diff[N-1:0];
            q_sh <= {q_sh[N-2:0], 1'b1};
          end else begin
            prem <= shifted[N-1:0];
            q_sh <= {q_sh[N-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -q_full : q_full;
          remainder <= APPROX_EN ? '0 : (neg_r ? -prem : prem);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed self-checking bench for signed_seq_divider (N=16); expectations follow DIV_APPROX_EN.
module tb_signed_seq_divider;
  localparam int N = 16;
`ifdef DIV_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int ITER = APPROX ? 12 : 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  signed_seq_divider #(.N(N), .APPROX_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts the accept edge as cycle 1; -1 means out_valid never rose.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic z, output int lat);
    int ai = int'($signed(a));
    int bi = int'($signed(b));
    int m;
    if (bi == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else if (ai == -32768 && bi == -1) begin
      q = 16'h8000; r = '0; z = 1'b0; lat = 1;
    end else begin
      z = 1'b0; lat = ITER + 2;
      if (!APPROX) begin
        q = 16'(ai / bi);
        r = 16'(ai % bi);
      end else begin
        m = (((ai < 0) ? -ai : ai) / ((bi < 0) ? -bi : bi)) / 16 * 16;
        q = ((ai < 0) != (bi < 0)) ? 16'(-m) : 16'(m);
        r = '0;
      end
    end
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== '0) begin
      errors++; $display("FAIL reset_outputs: q=%h r=%h dbz=%b want all 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_exact;
    logic [N-1:0] va [3] = '{16'd100, 16'hFF9C, 16'd100};
    logic [N-1:0] vb [3] = '{16'd7,   16'd7,   16'hFFF9};
    logic [N-1:0] eq [3] = '{16'd14,  16'hFFF2, 16'hFFF2};
    logic [N-1:0] er [3] = '{16'd2,   16'hFFFE, 16'd2};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 18) begin
        errors++; $display("FAIL exact_latency[%0d]: got %0d want 18", i, lat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
        errors++; $display("FAIL exact_result[%0d]: q=%h r=%h dbz=%b want q=%h r=%h dbz=0",
                           i, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_approx;
    logic [N-1:0] va [2] = '{16'd1000, 16'hFC18};
    logic [N-1:0] eq [2] = '{16'h0140, 16'hFEC0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], 16'd3);
      wait_valid(lat);
      checks++;
      if (lat !== 14) begin
        errors++; $display("FAIL approx_latency[%0d]: got %0d want 14", i, lat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq[i], 16'h0000, 1'b0}) begin
        errors++; $display("FAIL approx_result[%0d]: q=%h r=%h dbz=%b want q=%h r=0000 dbz=0",
                           i, quotient, remainder, div_by_zero, eq[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_special;
    int lat;
    start_op(16'd1234, 16'd0);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL dbz_latency: got %0d want 1", lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'd1234, 1'b1}) begin
      errors++; $display("FAIL dbz_result: q=%h r=%h dbz=%b want q=ffff r=04d2 dbz=1", quotient, remainder, div_by_zero);
    end
    finish_op();
    start_op(16'h8000, 16'hFFFF);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL ovf_latency: got %0d want 1", lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {16'h8000, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL ovf_result: q=%h r=%h dbz=%b want q=8000 r=0000 dbz=0", quotient, remainder, div_by_zero);
    end
    finish_op();
  endtask

  task automatic test_backpressure;
    logic [N-1:0] eq = APPROX ? 16'd320 : 16'd333;
    logic [N-1:0] er = APPROX ? 16'd0 : 16'd1;
    int lat;
    start_op(16'd1000, 16'd3);
    wait_valid(lat);
    dividend = 16'd5;
    divisor  = 16'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, eq, er}) begin
        errors++; $display("FAIL backpressure_hold[%0d]: ov=%b ir=%b q=%h r=%h want ov=1 ir=0 q=%h r=%h",
                           i, out_valid, in_ready, quotient, remainder, eq, er);
      end
    end
    in_valid = 1'b0;
    finish_op();
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL backpressure_release: ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    start_op(16'd100, 16'd7);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL midop_reset: ir=%b ov=%b q=%h want ir=1 ov=0 q=0000", in_ready, out_valid, quotient);
    end
    start_op(16'd9, 16'd3);
    wait_valid(lat);
    checks++;
    if (lat !== ITER + 2) begin
      errors++; $display("FAIL midop_after_latency: got %0d want %0d", lat, ITER + 2);
    end
    checks++;
    if ({quotient, remainder} !== {(APPROX ? 16'd0 : 16'd3), 16'd0}) begin
      errors++; $display("FAIL midop_after_result: q=%h r=%h want q=%h r=0000",
                         quotient, remainder, (APPROX ? 16'd0 : 16'd3));
    end
    finish_op();
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] va [10] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
                              16'h8000, 16'd12345, 16'hFFF9, 16'd0, 16'h7FFF};
    logic [N-1:0] vb [10] = '{16'd7, 16'd1, 16'h8000, 16'h8000, 16'd0,
                              16'hFFFF, 16'hFF85, 16'd2, 16'd5, 16'd1};
    logic [N-1:0] eq, er;
    logic ez;
    int elat, lat;
    start_op(va[0], vb[0]);
    for (int i = 0; i < 10; i++) begin
      model(va[i], vb[i], eq, er, ez, elat);
      wait_valid(lat);
      checks++;
      if (lat !== elat) begin
        errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, elat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        errors++; $display("FAIL b2b_result[%0d]: %h/%h q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                           i, va[i], vb[i], quotient, remainder, div_by_zero, eq, er, ez);
      end
      if (i < 9) begin
        // Next op is offered during the output handshake; it must wait for IDLE.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = va[i+1];
        divisor   = vb[i+1];
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
          errors++; $display("FAIL b2b_handoff[%0d]: ir=%b ov=%b want ir=1 ov=0", i, in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end else begin
        finish_op();
      end
    end
  endtask

  initial begin
    test_reset();
    if (APPROX) test_approx();
    else        test_exact();
    test_special();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
